// File: rtl/cblock_pkg.sv
// Shared definitions for the parametrised connection block: per-track field
// layout, configuration width helper and the serial loader state encoding.
package cblock_pkg;

    localparam int PASS    = 0;
    localparam int UP2T    = 1;
    localparam int DOWN2T  = 2;
    localparam int T2UP    = 3;
    localparam int T2DOWN  = 4;
    localparam int REG     = 5;
    localparam int FIELD_W = 6;

    // Per-track fields plus the two vertical pass bits.
    function automatic int cfg_width(input int w);
        return FIELD_W * w + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } cfg_state_e;

endpackage

// File: rtl/cblock_cfg_loader.sv
// Serial configuration loader: shifts bits LSB-first into a shadow register
// and raises a one-cycle commit strobe once a full word has been accepted.
module cblock_cfg_loader
    import cblock_pkg::*;
#(
    parameter int CFG_W = 20
)
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cfg_start_i,
    input  logic             cfg_valid_i,
    input  logic             cfg_bit_i,
    output logic             cfg_ready_o,
    output logic             commit_o,
    output logic [CFG_W-1:0] shadow_o
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);

    cfg_state_e       state_q;
    cfg_state_e       state_d;
    logic [CNT_W-1:0] count_q;
    logic [CFG_W-1:0] shadow_q;
    logic             accept;

    // A restart request in SHIFT takes precedence over a bit in the same cycle.
    assign accept   = (state_q == SHIFT) && cfg_valid_i && !cfg_start_i;
    assign shadow_o = shadow_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q != COMMIT) && cfg_start_i) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 1'b1;
            end
            if (accept) begin
                shadow_q <= {cfg_bit_i, shadow_q[CFG_W-1:1]};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        commit_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cfg_ready_o = 1'b1;
                if (accept && (count_q == LAST)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit_o = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cblock_param.sv
// W-track connection block: active configuration register, conflict check,
// prioritised routing muxes and optional per-track output registers.
module cblock_param
    import cblock_pkg::*;
#(
    parameter int W = 3
)
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         cfg_start_i,
    input  logic         cfg_valid_i,
    input  logic         cfg_bit_i,
    output logic         cfg_ready_o,
    output logic         cfg_done_o,
    output logic         cfg_err_o,
    input  logic [W-1:0] left_i,
    output logic [W-1:0] right_o,
    output logic [W-1:0] right_oe_o,
    input  logic         up_i,
    output logic         up_o,
    output logic         up_oe_o,
    input  logic         down_i,
    output logic         down_o,
    output logic         down_oe_o
);

    localparam int CFG_W  = cfg_width(W);
    localparam int V_UP   = FIELD_W * W;
    localparam int V_DOWN = FIELD_W * W + 1;

    logic [CFG_W-1:0] shadow;
    logic             commit;
    logic [CFG_W-1:0] active_q;
    logic             err_q;
    logic [W-1:0]     comb_val;
    logic [W-1:0]     comb_oe;
    logic [W-1:0]     reg_sel;
    logic [W-1:0]     reg_val_q;
    logic [W-1:0]     reg_oe_q;
    logic             up_val;
    logic             up_en;
    logic             down_val;
    logic             down_en;

    cblock_cfg_loader #(
        .CFG_W (CFG_W)
    ) u_loader (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cfg_start_i (cfg_start_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_bit_i   (cfg_bit_i),
        .cfg_ready_o (cfg_ready_o),
        .commit_o    (commit),
        .shadow_o    (shadow)
    );

    // Conflicts are judged on the word about to become active, so the flag
    // changes in lockstep with the routing it describes.
    function automatic logic has_conflict(input logic [CFG_W-1:0] c);
        int   up_n;
        int   down_n;
        logic bad;
        logic p;
        logic u;
        logic d;
        bad    = 1'b0;
        up_n   = c[V_UP]   ? 1 : 0;
        down_n = c[V_DOWN] ? 1 : 0;
        for (int t = 0; t < W; t++) begin
            p = c[FIELD_W*t + PASS];
            u = c[FIELD_W*t + UP2T];
            d = c[FIELD_W*t + DOWN2T];
            if ((p & u) | (p & d) | (u & d)) bad = 1'b1;
            if (c[FIELD_W*t + REG] && !(p | u | d)) bad = 1'b1;
            if (c[FIELD_W*t + T2UP])   up_n   = up_n + 1;
            if (c[FIELD_W*t + T2DOWN]) down_n = down_n + 1;
        end
        return bad || (up_n > 1) || (down_n > 1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q  <= '0;
            err_q     <= 1'b0;
            reg_val_q <= '0;
            reg_oe_q  <= '0;
        end else begin
            if (commit) begin
                active_q <= shadow;
                err_q    <= has_conflict(shadow);
            end
            reg_val_q <= comb_val;
            reg_oe_q  <= comb_oe;
        end
    end

    always_comb begin
        comb_val = '0;
        comb_oe  = '0;
        reg_sel  = '0;
        for (int t = 0; t < W; t++) begin
            if (active_q[FIELD_W*t + PASS]) begin
                comb_val[t] = left_i[t];
            end else if (active_q[FIELD_W*t + UP2T]) begin
                comb_val[t] = up_i;
            end else if (active_q[FIELD_W*t + DOWN2T]) begin
                comb_val[t] = down_i;
            end
            comb_oe[t] = active_q[FIELD_W*t + PASS] | active_q[FIELD_W*t + UP2T]
                       | active_q[FIELD_W*t + DOWN2T];
            reg_sel[t] = active_q[FIELD_W*t + REG];
        end
    end

    // Vertical pass wins; otherwise the lowest-index tapping track drives.
    always_comb begin
        up_val   = 1'b0;
        up_en    = 1'b0;
        down_val = 1'b0;
        down_en  = 1'b0;
        if (active_q[V_UP]) begin
            up_val = down_i;
            up_en  = 1'b1;
        end
        if (active_q[V_DOWN]) begin
            down_val = up_i;
            down_en  = 1'b1;
        end
        for (int t = 0; t < W; t++) begin
            if (!up_en && active_q[FIELD_W*t + T2UP]) begin
                up_val = left_i[t];
                up_en  = 1'b1;
            end
            if (!down_en && active_q[FIELD_W*t + T2DOWN]) begin
                down_val = left_i[t];
                down_en  = 1'b1;
            end
        end
    end

    assign right_o    = (reg_sel & reg_val_q) | (~reg_sel & comb_val);
    assign right_oe_o = (reg_sel & reg_oe_q)  | (~reg_sel & comb_oe);
    assign up_o       = up_val;
    assign up_oe_o    = up_en;
    assign down_o     = down_val;
    assign down_oe_o  = down_en;
    assign cfg_done_o = commit;
    assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_cblock_param.sv
// Scoreboard bench for cblock_param: stimulus queues expected output words
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_cblock_param;

    localparam int W = 3;
    localparam logic [11:0] ALL = 12'hFFF;
    localparam logic [11:0] RDY = 12'h002;

    logic         clk_i       = 1'b0;
    logic         reset_i     = 1'b1;
    logic         cfg_start_i = 1'b0;
    logic         cfg_valid_i = 1'b0;
    logic         cfg_bit_i   = 1'b0;
    logic         cfg_ready_o;
    logic         cfg_done_o;
    logic         cfg_err_o;
    logic [W-1:0] left_i      = '0;
    logic [W-1:0] right_o;
    logic [W-1:0] right_oe_o;
    logic         up_i        = 1'b0;
    logic         up_o;
    logic         up_oe_o;
    logic         down_i      = 1'b0;
    logic         down_o;
    logic         down_oe_o;

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        logic [11:0] mask;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          done_q[$];
    int          cyc          = 0;
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [11:0] act;

    cblock_param #(.W(W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cfg_start_i (cfg_start_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_bit_i   (cfg_bit_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_done_o  (cfg_done_o),
        .cfg_err_o   (cfg_err_o),
        .left_i      (left_i),
        .right_o     (right_o),
        .right_oe_o  (right_oe_o),
        .up_i        (up_i),
        .up_o        (up_o),
        .up_oe_o     (up_oe_o),
        .down_i      (down_i),
        .down_o      (down_o),
        .down_oe_o   (down_oe_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign act = {right_o, right_oe_o, up_o, up_oe_o, down_o, down_oe_o, cfg_ready_o, cfg_err_o};

    function automatic logic [11:0] pk(input logic [2:0] r, input logic [2:0] roe,
                                       input logic u, input logic uoe,
                                       input logic d, input logic doe,
                                       input logic rdy, input logic err);
        return {r, roe, u, uoe, d, doe, rdy, err};
    endfunction

    // Monitor: compare every expectation due this cycle, and police cfg_done_o.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            tests_run++;
            if (e.cyc != cyc) begin
                tests_failed++;
                $display("[TB] FAIL %s: check due at cycle %0d not taken (now %0d)", e.name, e.cyc, cyc);
            end else if ((act & e.mask) !== (e.exp & e.mask)) begin
                tests_failed++;
                $display("[TB] FAIL %s: cycle %0d got %03h required %03h (mask %03h)",
                         e.name, cyc, act & e.mask, e.exp & e.mask, e.mask);
            end
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            tests_run++;
            if (cfg_done_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL done_pulse: cycle %0d got %b required 1", cyc, cfg_done_o);
            end
        end else if (cfg_done_o !== 1'b0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_extra: cycle %0d got %b required 0", cyc, cfg_done_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] left, input logic up, input logic down);
        left_i = left;
        up_i   = up;
        down_i = down;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] exp, input logic [11:0] mask);
        exp_q.push_back('{cyc, exp, mask, name});
    endtask

    // Sends 20 bits LSB-first; the commit pulse is due the cycle after the last accept.
    task automatic shiftBits(input logic [19:0] cfg);
        for (int i = 0; i < 20; i++) begin
            cfg_valid_i = 1'b1;
            cfg_bit_i   = cfg[i];
            if (i == 0)  checkOutput("ready_shift", pk(0, 0, 0, 0, 0, 0, 1, 0), RDY);
            if (i == 19) done_q.push_back(cyc + 1);
            tick();
        end
        cfg_valid_i = 1'b0;
        cfg_bit_i   = 1'b0;
        tick();
    endtask

    task automatic loadConfig(input logic [19:0] cfg);
        cfg_start_i = 1'b1;
        tick();
        cfg_start_i = 1'b0;
        shiftBits(cfg);
    endtask

    initial begin
        $display("[TB] starting cblock_param bench");
        repeat (3) tick();
        reset_i = 1'b0;
        applyStimulus(3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("reset_idle", pk(0, 0, 0, 0, 0, 0, 0, 0), ALL);
            tick();
        end

        applyStimulus(3'b101, 1'b0, 1'b1);
        loadConfig(20'hC1041);
        checkOutput("all_pass_a", pk(3'b101, 3'b111, 1, 1, 0, 1, 0, 0), ALL);
        tick();
        applyStimulus(3'b010, 1'b1, 1'b0);
        checkOutput("all_pass_b", pk(3'b010, 3'b111, 0, 1, 1, 1, 0, 0), ALL);
        tick();

        applyStimulus(3'b000, 1'b0, 1'b0);
        loadConfig(20'h00840);
        checkOutput("reg_settle", pk(3'b000, 3'b010, 0, 0, 0, 0, 0, 0), ALL);
        tick();
        applyStimulus(3'b010, 1'b0, 1'b0);
        checkOutput("reg_n", pk(3'b000, 3'b010, 0, 0, 0, 0, 0, 0), ALL);
        tick();
        checkOutput("reg_n1", pk(3'b010, 3'b010, 0, 0, 0, 0, 0, 0), ALL);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("reg_hold", pk(3'b010, 3'b010, 0, 0, 0, 0, 0, 0), ALL);
        tick();
        checkOutput("reg_fall", pk(3'b000, 3'b010, 0, 0, 0, 0, 0, 0), ALL);
        tick();

        applyStimulus(3'b001, 1'b0, 1'b0);
        loadConfig(20'h00003);
        checkOutput("pass_wins_a", pk(3'b001, 3'b001, 0, 0, 0, 0, 0, 1), ALL);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0);
        checkOutput("pass_wins_b", pk(3'b000, 3'b001, 0, 0, 0, 0, 0, 1), ALL);
        tick();

        applyStimulus(3'b001, 1'b0, 1'b0);
        loadConfig(20'h08008);
        checkOutput("t2up_dup_a", pk(3'b000, 3'b000, 1, 1, 0, 0, 0, 1), ALL);
        tick();
        applyStimulus(3'b100, 1'b0, 1'b0);
        checkOutput("t2up_dup_b", pk(3'b000, 3'b000, 0, 1, 0, 0, 0, 1), ALL);
        tick();

        // Restart after 7 bits; the bit presented with the restart is dropped.
        applyStimulus(3'b011, 1'b1, 1'b1);
        cfg_start_i = 1'b1;
        tick();
        cfg_start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_valid_i = 1'b1;
            cfg_bit_i   = 1'b1;
            tick();
        end
        cfg_start_i = 1'b1;
        cfg_bit_i   = 1'b1;
        checkOutput("restart_ready", pk(0, 0, 0, 0, 0, 0, 1, 0), RDY);
        tick();
        cfg_start_i = 1'b0;
        shiftBits(20'h00001);
        checkOutput("restart_cfg", pk(3'b001, 3'b001, 0, 0, 0, 0, 0, 0), ALL);
        tick();

        // Reset mid-SHIFT, then keep offering bits that IDLE must ignore.
        cfg_start_i = 1'b1;
        tick();
        cfg_start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid_i = 1'b1;
            cfg_bit_i   = 1'b1;
            tick();
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checkOutput("reset_shift", pk(0, 0, 0, 0, 0, 0, 0, 0), ALL);
        for (int i = 0; i < 22; i++) begin
            cfg_valid_i = 1'b1;
            cfg_bit_i   = i[0];
            if (i % 7 == 3) checkOutput("idle_ignores", pk(0, 0, 0, 0, 0, 0, 0, 0), ALL);
            tick();
        end
        cfg_valid_i = 1'b0;
        checkOutput("reset_final", pk(0, 0, 0, 0, 0, 0, 0, 0), ALL);
        repeat (3) tick();

        tests_run++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: pending checks %0d/%0d required 0/0", exp_q.size(), done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
